muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU commands and runs a one-bit-per-cycle shift-add or restoring-divide loop for WIDTH cycles.
- Applies sign correction and writes HI/LO.
- Exposes busy so the pipeline stalls MFHI/MFLO and further mul/div issue until done.
- Also services MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width; HI/LO width; iteration count.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe, sampled only when busy=0
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; new HI/LO visible this cycle
div_by_zero  out  1  pulses with done when DIV/DIVU had b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts with no done pulse and no HI/LO update.
- States:
  - IDLE: start=1 latches op, |a|, |b| (magnitudes only for signed ops), result-sign and remainder-sign flags. Goes to RUN with counter=WIDTH. For DIV/DIVU with b==0, goes straight to FIX with the dbz flag set.
  - RUN: one iteration per cycle; counter decrements; at counter==1 goes to FIX.
  - FIX: sign-corrects the result; writes HI/LO unless dbz; goes to IDLE.
- Timing:
  - busy=1 in every cycle the state is not IDLE.
  - done and div_by_zero are registered and high for exactly the one cycle after FIX, which is the first IDLE cycle.
- Latency: start sampled in cycle t → done in cycle t+WIDTH+2 (t+2 for divide-by-zero). A new start is accepted in the done cycle.
- Multiply:
  - Unsigned 2*WIDTH product: hi=product[2W-1:W], lo=product[W-1:0].
  - Signed: the full 2W product is two's-complement negated when operand signs differ.
  - -2^(W-1) magnitude is 2^(W-1) unsigned; no overflow.
- Divide:
  - Restoring, MSB first: lo=quotient, hi=remainder.
  - Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no flag).
- Divide by zero: HI/LO unchanged; div_by_zero=1 with done.
- start while busy is ignored (no queueing, no error). An undefined op is impossible (2-bit op fully decoded).
- MTHI/MTLO:
  - When busy=0, hi_we/lo_we write wdata at the next edge.
  - When busy=1, the writes are ignored.
  - start and hi_we/lo_we in the same IDLE cycle: the write takes effect; the later FIX overwrites it.
- Operands a/b may change after the start cycle without effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at t → busy t+1..t+33, done at t+34, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 → hi=0x40000000 lo=0.
- DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload via MTHI=0x1234, MTLO=0x5678, then DIVU a=5 b=0 → done and div_by_zero at t+2; hi=0x1234 and lo=0x5678 unchanged.
- Back-to-back:
  - start again in a done cycle → accepted; second done exactly 34 cycles later.
  - start pulses and hi_we pulses during busy → ignored; HI reflects only the operation result.
- reset=1 at RUN cycle 10 → next cycle busy=0, hi=lo=0, done never pulses; a fresh MULTU 6*7 then gives lo=42 hi=0.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Command/result bundle between the pipeline and the HI/LO multiply/divide sequencer.
// start is a request that is taken only in a cycle where busy=0; while busy=1 it is dropped, never queued.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative one-bit-per-cycle multiply (shift-add) / restoring divide owning the HI/LO pair.
// Operands are reduced to magnitudes at start; signs are re-applied in the FIX cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, m_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, neg_res_q, neg_rem_q, dbz_q;
  logic             done_q, dbz_out_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // Multiply: acc_lo holds the remaining multiplier bits and fills with product bits from the top.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, m_q});
  assign div_rem   = div_shift[WIDTH-1:0] - m_q;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.op[1] && bus.b == '0) ? FIX : RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        bus.busy = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q    <= (state_q == FIX);
      dbz_out_q <= (state_q == FIX) && dbz_q;
      case (state_q)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div_q  <= bus.op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= bus.op[1] && (bus.b == '0);
            acc_hi_q  <= '0;
            acc_lo_q  <= a_mag;
            m_q       <= b_mag;
            cnt_q     <= CW'(WIDTH);
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (is_div_q) begin
            acc_hi_q <= div_ok ? div_rem : div_shift[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ok};
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!dbz_q) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq with a 64-bit arithmetic reference model of HI/LO.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] exp_hi, exp_lo;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic dbz, output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint sa, sb, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    rh = '0;
    rl = '0;
    case (op)
      2'b00: begin
        up = {32'd0, a} * {32'd0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      2'b01: begin
        sp = sa * sb;
        rh = sp[63:32];
        rl = sp[31:0];
      end
      2'b10: begin
        if (b == 0) dbz = 1'b1;
        else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: begin
        if (b == 0) dbz = 1'b1;
        else begin
          sp = sa / sb;
          rl = sp[31:0];
          sp = sa % sb;
          rh = sp[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] data);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = data;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (hw) exp_hi = data;
    if (lw) exp_lo = data;
    check("mt_hi", bus.hi, exp_hi);
    check("mt_lo", bus.lo, exp_lo);
  endtask

  // Called at a negedge while idle; returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise, input bit we_start);
    logic e_dbz;
    logic [W-1:0] rh, rl;
    int lat, seen;
    bit busy_ok;
    model(op, a, b, e_dbz, rh, rl);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    if (we_start) begin
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = $urandom;
      exp_hi = bus.wdata;
      exp_lo = bus.wdata;
    end
    lat = e_dbz ? 2 : W + 2;
    seen = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= lat + 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      if (bus.done) begin
        seen = n;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 2'($urandom_range(0, 3));
        bus.hi_we = 1'($urandom_range(0, 1));
        bus.lo_we = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
      end
    end
    check("latency", seen, lat);
    check("busy_during_op", busy_ok, 1);
    check("busy_at_done", bus.busy, 0);
    check("div_by_zero", bus.div_by_zero, e_dbz);
    if (!e_dbz) begin
      exp_hi = rh;
      exp_lo = rl;
    end
    check("hi", bus.hi, exp_hi);
    check("lo", bus.lo, exp_lo);
  endtask

  initial begin
    bit done_seen;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed operands; consecutive calls also start each op in the previous done cycle.
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_hi", bus.hi, 32'hFFFFFFFE);
    check("multu_max_lo", bus.lo, 32'h00000001);
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, 0, 0);
    check("mult_neg_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_neg_lo", bus.lo, 32'hFFFFFFEB);
    run_op(2'b01, 32'h80000000, 32'h80000000, 0, 0);
    check("mult_min_hi", bus.hi, 32'h40000000);
    check("mult_min_lo", bus.lo, 32'h0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    check("div_neg_hi", bus.hi, 32'hFFFFFFFF);
    run_op(2'b10, 32'd7, 32'd2, 0, 0);
    check("divu_lo", bus.lo, 32'd3);
    check("divu_hi", bus.hi, 32'd1);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf_lo", bus.lo, 32'h80000000);
    check("div_ovf_hi", bus.hi, 32'h0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);

    mt_write(1, 0, 32'h1234);
    mt_write(0, 1, 32'h5678);
    run_op(2'b10, 32'd5, 32'd0, 0, 0);
    check("dbz_hi_kept", bus.hi, 32'h1234);
    check("dbz_lo_kept", bus.lo, 32'h5678);
    @(negedge clk);
    check("dbz_one_cycle", bus.div_by_zero, 0);

    for (int i = 0; i < 4; i++) run_op(2'($urandom_range(0, 3)), $urandom, pick(), 1, 0);

    // Reset in the tenth RUN cycle aborts the operation.
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.a = 32'h12345678;
    bus.b = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 0);
    run_op(2'b00, 32'd6, 32'd7, 0, 0);
    check("post_abort_lo", bus.lo, 32'd42);
    check("post_abort_hi", bus.hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(2'($urandom_range(0, 3)), pick(), pick(),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
